// File: rtl/tt_capture.sv
// Truth-table capture engine: collects the response f for all 16 input combinations,
// flags inconsistent re-captures, and grades the finished table against a golden one.
module tt_capture #(
  parameter int unsigned SETTLE = 2  // cycles from vector acceptance to f sampling (1..15)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        vec_valid,
  input  logic [3:0]  vec,
  input  logic        f,
  input  logic [15:0] expected,
  output logic [15:0] table_out,
  output logic [15:0] covered,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        conflict,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail
);

  localparam logic [3:0] SettleInit = 4'(SETTLE);

  typedef enum logic [2:0] {StIdle, StCollect, StSettle, StCheck, StDone} state_e;

  state_e     state_q;
  logic [3:0] idx_q;
  logic [3:0] cnt_q;
  logic       f_q;

  logic [15:0] tbl_upd;
  logic [15:0] cov_upd;
  logic        conf_upd;
  logic [15:0] diff;
  logic [4:0]  miss_upd;
  logic [3:0]  ff_upd;

  // Table/coverage/conflict as they will be after the CHECK cycle, plus the grading
  // that DONE entry latches from that final table.
  always_comb begin
    tbl_upd  = table_out;
    cov_upd  = covered;
    conf_upd = conflict;
    if (!covered[idx_q]) begin
      tbl_upd[idx_q] = f_q;
      cov_upd[idx_q] = 1'b1;
    end else if (f_q != table_out[idx_q]) begin
      conf_upd = 1'b1;
    end
    diff     = tbl_upd ^ expected;
    miss_upd = '0;
    ff_upd   = '0;
    for (int i = 0; i < 16; i++) begin
      miss_upd = miss_upd + 5'(diff[i]);
    end
    // Scan downward so the lowest failing index wins.
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) ff_upd = 4'(i);
    end
  end

  // Control FSM with all state and outputs registered; start overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      f_q          <= 1'b0;
      table_out    <= '0;
      covered      <= '0;
      conflict     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
    end else if (start) begin
      state_q      <= StCollect;
      cnt_q        <= '0;
      table_out    <= '0;
      covered      <= '0;
      conflict     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StCollect: begin
          if (vec_valid) begin
            idx_q   <= vec;
            cnt_q   <= SettleInit;
            busy    <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - 4'd1;
          // Counter hits zero on this edge: sample the response now.
          if (cnt_q == 4'd1) begin
            f_q     <= f;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          table_out <= tbl_upd;
          covered   <= cov_upd;
          conflict  <= conf_upd;
          busy      <= 1'b0;
          if (&cov_upd) begin
            done         <= 1'b1;
            pass         <= (miss_upd == 5'd0) && !conf_upd;
            mismatch_cnt <= miss_upd;
            first_fail   <= ff_upd;
            state_q      <= StDone;
          end else begin
            state_q <= StCollect;
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_capture.sv
// Self-checking bench for tt_capture: a reference model predicts the table after each
// accepted vector; predictions are queued at stimulus time and popped at capture time.
module tb_tt_capture;

  localparam int unsigned Settle = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        vec_valid = 1'b0;
  logic [3:0]  vec = '0;
  logic        f = 1'b0;
  logic [15:0] expected = '0;
  logic [15:0] table_out;
  logic [15:0] covered;
  logic        busy;
  logic        done;
  logic        pass;
  logic        conflict;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail;

  tt_capture #(.SETTLE(Settle)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vec_valid    (vec_valid),
    .vec          (vec),
    .f            (f),
    .expected     (expected),
    .table_out    (table_out),
    .covered      (covered),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .conflict     (conflict),
    .mismatch_cnt (mismatch_cnt),
    .first_fail   (first_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tbl;
    logic [15:0] cov;
    logic        conf;
  } cap_t;

  cap_t sb_q[$];

  logic [15:0] m_tbl = '0;
  logic [15:0] m_cov = '0;
  logic        m_conf = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, wanted %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_tbl  = '0;
    m_cov  = '0;
    m_conf = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    check("start_cov", covered, 16'h0);
    check("start_tbl", table_out, 16'h0);
    check("start_conf", conflict, 0);
    check("start_done", done, 0);
    check("start_busy", busy, 0);
  endtask

  // Apply one vector in COLLECT; optionally pulse a stray vec=7 strobe during SETTLE.
  task automatic apply_vec(input logic [3:0] v, input logic fv, input bit glitch);
    cap_t        e;
    logic [15:0] prev_cov;
    prev_cov = m_cov;
    if (!m_cov[v]) begin
      m_tbl[v] = fv;
      m_cov[v] = 1'b1;
    end else if (m_tbl[v] != fv) begin
      m_conf = 1'b1;
    end
    e.tbl = m_tbl;
    e.cov = m_cov;
    e.conf = m_conf;
    sb_q.push_back(e);
    @(negedge clk);
    vec = v;
    f = fv;
    vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    check("busy_settle", busy, 1);
    for (int i = 0; i < int'(Settle); i++) begin
      if (glitch && i == 0) begin
        vec = 4'd7;
        vec_valid = 1'b1;
      end
      @(negedge clk);
      vec_valid = 1'b0;
    end
    // One cycle before capture: nothing written yet.
    check("pre_cap_cov", covered, prev_cov);
    check("busy_check", busy, 1);
    @(negedge clk);
    e = sb_q.pop_front();
    check("cap_tbl", table_out, e.tbl);
    check("cap_cov", covered, e.cov);
    check("cap_conf", conflict, e.conf);
    check("cap_busy", busy, 0);
    check("cap_done", done, &e.cov);
  endtask

  task automatic check_done(input logic [15:0] exp);
    logic [15:0] d;
    logic [3:0]  ff;
    int          mc;
    d  = m_tbl ^ exp;
    mc = $countones(d);
    ff = '0;
    for (int i = 15; i >= 0; i--) if (d[i]) ff = 4'(i);
    check("done", done, 1);
    check("mismatch_cnt", mismatch_cnt, mc);
    check("first_fail", first_fail, ff);
    check("pass", pass, (mc == 0) && !m_conf);
    check("final_tbl", table_out, m_tbl);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tbl"}, table_out, 0);
    check({tag, "_cov"}, covered, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_conf"}, conflict, 0);
    check({tag, "_mcnt"}, mismatch_cnt, 0);
    check({tag, "_ff"}, first_fail, 0);
  endtask

  localparam logic [15:0] Gold = 16'hA5C3;

  initial begin
    logic [15:0] g;
    g = Gold;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean ascending sweep; golden value only valid from the last vector onward.
    expected = 16'hFFFF;
    do_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) expected = Gold;
      apply_vec(4'(i), g[i], 1'b0);
    end
    check_done(Gold);
    check("sweep_tbl", table_out, 16'hA5C3);
    expected = 16'h0000;
    @(negedge clk);
    vec = 4'd2;
    vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_done(Gold);

    // Two injected faults.
    expected = Gold;
    do_start();
    for (int i = 0; i < 16; i++) apply_vec(4'(i), g[i] ^ (i == 4 || i == 9), 1'b0);
    check_done(Gold);
    check("fault_mcnt", mismatch_cnt, 2);
    check("fault_ff", first_fail, 4);

    // Conflicting re-capture of vector 3.
    do_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        apply_vec(4'd3, 1'b1, 1'b0);
        apply_vec(4'd3, 1'b0, 1'b0);
      end else begin
        apply_vec(4'(i), g[i], 1'b0);
      end
    end
    check_done(Gold);
    check("conf_flag", conflict, 1);
    check("conf_bit3", table_out[3], 1);

    // Stray strobe during SETTLE must not capture vector 7.
    do_start();
    for (int i = 0; i < 16; i++) if (i != 7) apply_vec(4'(i), g[i], i == 6);
    check("glitch_cov7", covered[7], 0);
    check("glitch_notdone", done, 0);
    apply_vec(4'd7, g[7], 1'b0);
    check_done(Gold);

    // Abort after 8 captures, then a full descending sweep.
    do_start();
    for (int i = 0; i < 8; i++) apply_vec(4'(i), ~g[i], 1'b0);
    do_start();
    for (int i = 15; i >= 0; i--) apply_vec(4'(i), g[i], 1'b0);
    check_done(Gold);

    // Asynchronous reset in the middle of SETTLE.
    do_start();
    apply_vec(4'd1, g[1], 1'b0);
    @(negedge clk);
    vec = 4'd5;
    f = g[5];
    vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    // IDLE after reset ignores strobes.
    @(negedge clk);
    vec = 4'd2;
    vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    repeat (Settle + 2) @(negedge clk);
    check("idle_cov", covered, 0);
    check("idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tt_capture.md
TT_CAPTURE -- requirements
Module: tt_capture

Interface
REQ-001 Parameter SETTLE, default 2: clock cycles to wait after a vector is accepted before f is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  single-cycle pulse; clears the capture and begins a new 16-vector collection.
REQ-005 vec_valid  input  1  single-cycle strobe; vec holds the input combination now applied to the device under test.
REQ-006 vec  input  4  applied combination {A,B,C,D}, A = MSB.
REQ-007 f  input  1  device-under-test response.
REQ-008 expected  input  16  golden truth table; bit i = expected f for vec == i; sampled only in the cycle DONE is entered.
REQ-009 table_out  output  16  captured truth table; bit i = f captured for vec == i.
REQ-010 covered  output  16  bit i set once vec == i has been captured.
REQ-011 busy  output  1  high in SETTLE and CHECK states.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass  output  1  valid while done: table_out == expected and no conflict.
REQ-014 conflict  output  1  sticky: a re-applied vector produced a different f than its first capture.
REQ-015 mismatch_cnt  output  5  valid while done: popcount(table_out XOR expected), range 0..16.
REQ-016 first_fail  output  4  valid while done: lowest index i with mismatch; 0 when mismatch_cnt == 0.

Function
REQ-017 FSM states IDLE, COLLECT, SETTLE, CHECK, DONE; encoding free.
REQ-018 IDLE: vec_valid ignored; start -> COLLECT with table_out, covered, conflict cleared.
REQ-019 COLLECT: vec_valid -> latch vec into internal index register, load settle counter with SETTLE, go SETTLE.
REQ-020 SETTLE: counter decrements each cycle; on the cycle it reaches 0, f is sampled and the FSM goes CHECK; total latency vec_valid to capture = SETTLE+1 cycles.
REQ-021 CHECK (one cycle): if covered[idx]==0, write table_out[idx]=sampled f and set covered[idx]; if covered[idx]==1 and sampled f != table_out[idx], set conflict, table_out unchanged; if equal, no change.
REQ-022 CHECK exit: if covered is all ones after the update -> DONE, else -> COLLECT.
REQ-023 Entering DONE registers pass, mismatch_cnt, first_fail from the final table_out and expected; values held until next start or reset.
REQ-024 vec_valid while in SETTLE, CHECK or DONE is ignored, not queued.
REQ-025 start in any non-IDLE state aborts and restarts: same clearing as REQ-018, next state COLLECT; start has priority over vec_valid in the same cycle.
REQ-026 Vectors may arrive in any order and repeat; duplicates never advance coverage.
REQ-027 pass = (mismatch_cnt == 0) AND NOT conflict.
REQ-028 Expected changing outside the DONE-entry cycle has no effect on results.

Reset
REQ-029 rst_n low forces IDLE immediately, regardless of clock.
REQ-030 Reset values: table_out=0, covered=0, busy=0, done=0, pass=0, conflict=0, mismatch_cnt=0, first_fail=0, settle counter=0.
REQ-031 Reset mid-collection discards all captured data; no partial result is retained.

Verification
REQ-032 Ascending sweep: start, vec 0..15 each with vec_valid, f = expected bit, expected=16'hA5C3 -> done=1, pass=1, mismatch_cnt=0, table_out=16'hA5C3; capture occurs SETTLE+1 cycles after each strobe.
REQ-033 Two faults: same sweep but f inverted for vec 4 and 9 -> done=1, pass=0, mismatch_cnt=2, first_fail=4.
REQ-034 Conflict: vec 3 applied with f=1, later reapplied with f=0, all others correct -> conflict=1, table_out[3]=1, pass=0.
REQ-035 Ignored strobe: vec_valid pulsed during SETTLE with vec=7 -> covered[7] unchanged; done not reached until vec 7 applied in COLLECT.
REQ-036 Abort: start after 8 captures -> covered=0 next cycle, state COLLECT; full 16-vector sweep then completes normally.
REQ-037 Async reset: rst_n asserted mid-SETTLE between clock edges -> all outputs 0 before next rising edge; state IDLE.
